// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
//   state_e  : padder FSM states
//   block_t  : 512-bit block as 16 big-endian 32-bit words, index 0 = first word
//   PAD_MARKER, pad_last_word() : end-of-message marker handling
package sha256_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLK_WORDS = 16;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2,
        TAIL = 2'd3
    } state_e;

    typedef logic [BLK_WORDS-1:0][WORD_W-1:0] block_t;

    localparam logic [WORD_W-1:0] PAD_MARKER = 32'h8000_0000;

    // Keep the first nb bytes of the final word, zero the rest and insert the
    // 0x80 marker right after the data; nb >= 4 returns the word untouched.
    function automatic logic [WORD_W-1:0] pad_last_word(input logic [WORD_W-1:0] d,
                                                        input logic [2:0]        nb);
        logic [WORD_W-1:0] w;
        case (nb)
            3'd0:    w = PAD_MARKER;
            3'd1:    w = {d[31:24], 24'h80_0000};
            3'd2:    w = {d[31:16], 16'h8000};
            3'd3:    w = {d[31:8],  8'h80};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects 32-bit big-endian message words into
// 512-bit blocks, appends the 0x80 marker, zero fill and the 64-bit bit length,
// and hands complete blocks to the hash core over a valid/ready handshake.
//   clk, reset                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_data      : message word stream
//   in_last/in_bytes               : final word flag and its valid byte count (0..4)
//   blk_valid/blk_ready/blk_word   : padded block output
//   blk_first/blk_last             : block is first / final of its message
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    input  logic [2:0]        in_bytes,
    output logic              blk_valid,
    input  logic              blk_ready,
    output block_t            blk_word,
    output logic              blk_first,
    output logic              blk_last
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned MIDX_W = 5;

    state_e             state_q,       state_d;
    block_t             words_q,       words_d;
    logic [IDX_W-1:0]   widx_q,        widx_d;
    logic [MIDX_W-1:0]  midx_q,        midx_d;
    logic [LEN_W-1:0]   bitlen_q,      bitlen_d;
    logic               first_q,       first_d;
    logic               last_q,        last_d;
    logic               tail_pend_q,   tail_pend_d;
    logic               marker_pend_q, marker_pend_d;
    logic               in_ready_q,    in_ready_d;
    logic               blk_valid_q,   blk_valid_d;
    logic               blk_first_q,   blk_first_d;
    logic               blk_last_q,    blk_last_d;

    logic [2:0]         nb;
    logic [63:0]        len64;

    // Byte counts above 4 are treated as a full word.
    assign nb    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign len64 = 64'(bitlen_q);

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        words_d       = words_q;
        widx_d        = widx_q;
        midx_d        = midx_q;
        bitlen_d      = bitlen_q;
        first_d       = first_q;
        last_d        = last_q;
        tail_pend_d   = tail_pend_q;
        marker_pend_d = marker_pend_q;

        case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    if (in_last) begin
                        words_d[widx_q] = pad_last_word(in_data, nb);
                        bitlen_d        = bitlen_q + LEN_W'({nb, 3'b000});
                        if (nb == 3'd4) begin
                            // Marker spills into the next word, possibly the next block.
                            midx_d = MIDX_W'(widx_q) + MIDX_W'(1);
                            if (widx_q != 4'd15) begin
                                words_d[widx_q + 4'd1] = PAD_MARKER;
                            end
                        end else begin
                            midx_d = MIDX_W'(widx_q);
                        end
                        state_d = PAD;
                    end else begin
                        words_d[widx_q] = in_data;
                        bitlen_d        = bitlen_q + LEN_W'(32);
                        widx_d          = widx_q + 4'd1;
                        if (widx_q == 4'd15) begin
                            last_d        = 1'b0;
                            tail_pend_d   = 1'b0;
                            marker_pend_d = 1'b0;
                            state_d       = EMIT;
                        end
                    end
                end
            end

            PAD: begin
                for (int i = 0; i < 16; i++) begin
                    if (MIDX_W'(i) > midx_q) begin
                        words_d[i] = '0;
                    end
                end
                if (midx_q <= MIDX_W'(13)) begin
                    words_d[14]   = len64[63:32];
                    words_d[15]   = len64[31:0];
                    last_d        = 1'b1;
                    tail_pend_d   = 1'b0;
                    marker_pend_d = 1'b0;
                end else begin
                    // No room for the length: it goes into an extra tail block.
                    last_d        = 1'b0;
                    tail_pend_d   = 1'b1;
                    marker_pend_d = (midx_q == MIDX_W'(16));
                end
                state_d = EMIT;
            end

            EMIT: begin
                if (blk_ready) begin
                    if (last_q) begin
                        bitlen_d = '0;
                        first_d  = 1'b1;
                        widx_d   = '0;
                    end else begin
                        first_d  = 1'b0;
                    end
                    if (tail_pend_q) begin
                        state_d = TAIL;
                    end else begin
                        widx_d  = '0;
                        state_d = FILL;
                    end
                end
            end

            TAIL: begin
                for (int i = 0; i < 14; i++) begin
                    words_d[i] = '0;
                end
                if (marker_pend_q) begin
                    words_d[0] = PAD_MARKER;
                end
                words_d[14]   = len64[63:32];
                words_d[15]   = len64[31:0];
                last_d        = 1'b1;
                tail_pend_d   = 1'b0;
                marker_pend_d = 1'b0;
                state_d       = EMIT;
            end

            default: state_d = FILL;
        endcase

        // Handshake outputs are registered copies of the upcoming state.
        in_ready_d  = (state_d == FILL);
        blk_valid_d = (state_d == EMIT);
        blk_first_d = (state_d == EMIT) && first_d;
        blk_last_d  = (state_d == EMIT) && last_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            words_q       <= '0;
            widx_q        <= '0;
            midx_q        <= '0;
            bitlen_q      <= '0;
            first_q       <= 1'b1;
            last_q        <= 1'b0;
            tail_pend_q   <= 1'b0;
            marker_pend_q <= 1'b0;
            in_ready_q    <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_first_q   <= 1'b0;
            blk_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            words_q       <= words_d;
            widx_q        <= widx_d;
            midx_q        <= midx_d;
            bitlen_q      <= bitlen_d;
            first_q       <= first_d;
            last_q        <= last_d;
            tail_pend_q   <= tail_pend_d;
            marker_pend_q <= marker_pend_d;
            in_ready_q    <= in_ready_d;
            blk_valid_q   <= blk_valid_d;
            blk_first_q   <= blk_first_d;
            blk_last_q    <= blk_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;
    assign blk_word  = words_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: hand-written corner sequences plus a
// table of message lengths checked against a byte-level padding model.
module tb_sha256_padder;
    import sha256_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [2:0]  in_bytes = '0;
    logic        blk_valid;
    logic        blk_ready = 1'b1;
    block_t      blk_word;
    logic        blk_first;
    logic        blk_last;

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_word  (blk_word),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int len;   // message length in bytes
        int nblk;  // expected number of padded blocks
    } vec_t;
    vec_t vecs[15];

    block_t cap_blk[8];
    logic   cap_first[8];
    logic   cap_last[8];
    int     cap_n;

    block_t exp_blk[8];
    int     exp_n;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int i);
        return 8'((i * 7 + 1) % 256);
    endfunction

    // Textbook padding: message, 0x80, zeros, 64-bit big-endian bit length.
    task automatic build_model(input int len);
        int          total;
        logic [63:0] bl;
        logic [7:0]  b;
        exp_n = (len + 8) / 64 + 1;
        total = exp_n * 64;
        bl    = 64'(len) * 64'd8;
        for (int i = 0; i < total; i++) begin
            if (i < len)              b = msg_byte(i);
            else if (i == len)        b = 8'h80;
            else if (i >= total - 8)  b = bl[8*(total-1-i) +: 8];
            else                      b = 8'h00;
            exp_blk[i/64][(i%64)/4][8*(3-(i%4)) +: 8] = b;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
        int cyc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = nb;
        while (!in_ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 1'b0, 1'b1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Bytes past the end of the message are 0xFF so zeroing is observable.
    task automatic send_msg(input int len);
        int          nw;
        logic [31:0] d;
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int j = 0; j < 4; j++) begin
                d[8*(3-j) +: 8] = (4*w + j < len) ? msg_byte(4*w + j) : 8'hFF;
            end
            if (w == nw - 1) send_word(d, 1'b1, 3'(len - 4*w));
            else             send_word(d, 1'b0, 3'd5);
        end
    endtask

    task automatic collect();
        int cyc = 0;
        bit done = 0;
        cap_n = 0;
        while (!done && cyc < 400) begin
            if (blk_valid && blk_ready) begin
                if (cap_n < 8) begin
                    cap_blk[cap_n]   = blk_word;
                    cap_first[cap_n] = blk_first;
                    cap_last[cap_n]  = blk_last;
                end
                cap_n++;
                if (blk_last) done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("collect_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_vec(input int len, input int nblk);
        fork
            send_msg(len);
            collect();
        join
        build_model(len);
        chk($sformatf("len%0d_nblk", len), 512'(cap_n), 512'(nblk));
        for (int k = 0; k < 8; k++) begin
            if (k < cap_n && k < exp_n) begin
                chk($sformatf("len%0d_blk%0d", len, k), cap_blk[k], exp_blk[k]);
                chk($sformatf("len%0d_first%0d", len, k), cap_first[k], k == 0);
                chk($sformatf("len%0d_last%0d", len, k), cap_last[k], k == exp_n - 1);
            end
        end
    endtask

    initial begin
        block_t exp;
        int     seen;

        vecs[0]  = '{0, 1};   vecs[1]  = '{3, 1};   vecs[2]  = '{4, 1};
        vecs[3]  = '{5, 1};   vecs[4]  = '{52, 1};  vecs[5]  = '{55, 1};
        vecs[6]  = '{56, 2};  vecs[7]  = '{59, 2};  vecs[8]  = '{60, 2};
        vecs[9]  = '{63, 2};  vecs[10] = '{64, 2};  vecs[11] = '{100, 2};
        vecs[12] = '{119, 2}; vecs[13] = '{120, 3}; vecs[14] = '{128, 3};

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk("rst_outputs", {blk_valid, blk_first, blk_last, in_ready}, 4'b0000);
        chk("rst_words", blk_word, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", in_ready, 1'b1);
        chk("rst_release_valid", blk_valid, 1'b0);

        // "abc" with a stalled consumer, checking the one-cycle PAD latency
        exp     = '0;
        exp[0]  = 32'h6162_6380;
        exp[15] = 32'h0000_0018;
        blk_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h6162_6300;
        in_last   = 1'b1;
        in_bytes  = 3'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abc_pad_valid", blk_valid, 1'b0);
        chk("abc_pad_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("abc_valid", blk_valid, 1'b1);
        chk("abc_block", blk_word, exp);
        chk("abc_first_last", {blk_first, blk_last}, 2'b11);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_hold", c), {blk_valid, in_ready, blk_first, blk_last}, 4'b1011);
            chk($sformatf("stall%0d_block", c), blk_word, exp);
        end
        blk_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (blk_valid) seen++;
            @(negedge clk);
        end
        chk("stall_one_transfer", 512'(seen), 512'(1));
        chk("stall_back_to_fill", in_ready, 1'b1);

        // Empty message
        fork send_msg(0); collect(); join
        exp    = '0;
        exp[0] = PAD_MARKER;
        chk("empty_nblk", 512'(cap_n), 512'(1));
        chk("empty_block", cap_blk[0], exp);
        chk("empty_first_last", {cap_first[0], cap_last[0]}, 2'b11);

        // 56 bytes: marker at word 14, length in a tail block
        fork send_msg(56); collect(); join
        chk("b56_nblk", 512'(cap_n), 512'(2));
        chk("b56_w14", cap_blk[0][14], PAD_MARKER);
        chk("b56_w15", cap_blk[0][15], 32'h0);
        chk("b56_flags0", {cap_first[0], cap_last[0]}, 2'b10);
        exp     = '0;
        exp[15] = 32'h0000_01C0;
        chk("b56_tail", cap_blk[1], exp);
        chk("b56_flags1", {cap_first[1], cap_last[1]}, 2'b01);

        // 64 bytes: marker carried into the tail block
        fork send_msg(64); collect(); join
        chk("b64_nblk", 512'(cap_n), 512'(2));
        chk("b64_w15_data", cap_blk[0][15], {msg_byte(60), msg_byte(61), msg_byte(62), msg_byte(63)});
        chk("b64_flags0", {cap_first[0], cap_last[0]}, 2'b10);
        exp     = '0;
        exp[0]  = PAD_MARKER;
        exp[15] = 32'h0000_0200;
        chk("b64_tail", cap_blk[1], exp);
        chk("b64_flags1", {cap_first[1], cap_last[1]}, 2'b01);

        // Table of message lengths against the padding model
        for (int v = 0; v < 15; v++) begin
            run_vec(vecs[v].len, vecs[v].nblk);
        end

        // Reset in the middle of a message drops it
        for (int w = 0; w < 7; w++) begin
            send_word(32'hDEAD_0000 | 32'(w), 1'b0, 3'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {blk_valid, in_ready}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (blk_valid) seen++;
        end
        chk("midrst_no_block", 512'(seen), 512'(0));
        fork send_word(32'h6162_6300, 1'b1, 3'd3); collect(); join
        exp     = '0;
        exp[0]  = 32'h6162_6380;
        exp[15] = 32'h0000_0018;
        chk("midrst_nblk", 512'(cap_n), 512'(1));
        chk("midrst_abc_block", cap_blk[0], exp);
        chk("midrst_abc_flags", {cap_first[0], cap_last[0]}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
